// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin A2D scanner issuing one conversion per slot and capturing results per slot.
// Optional macro POT_IIR_EN: captures after the first one per slot are smoothed by a 1/4-weight IIR.
module pot_scan_ctrl #(
    parameter int                      NUM_CH      = 6,
    parameter int                      RES_W       = 12,
    parameter int                      CH_W        = 3,
    parameter logic [NUM_CH*CH_W-1:0]  CH_MAP      = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter int                      SETTLE_CYC  = 4,
    parameter int                      TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr_err,
    input  logic                     cnv_cmplt,
    input  logic [RES_W-1:0]         res,
    output logic                     strt_cnv,
    output logic [CH_W-1:0]          chnnl,
    output logic [NUM_CH*RES_W-1:0]  pot_vals,
    output logic [NUM_CH-1:0]        pot_vld,
    output logic                     scan_done,
    output logic                     timeout_err
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t                     state_r;
    logic [IDX_W-1:0]           idx_r;
    logic [TMO_W-1:0]           tmo_cnt_r;
    logic [SET_W-1:0]           settle_cnt_r;
    logic                       strt_cnv_r;
    logic [CH_W-1:0]            chnnl_r;
    logic [NUM_CH*RES_W-1:0]    pot_vals_r;
    logic [NUM_CH-1:0]          pot_vld_r;
    logic                       scan_done_r;
    logic                       timeout_err_r;

    logic [IDX_W-1:0]           next_idx_s;
    logic                       wrap_s;
    logic [RES_W-1:0]           cap_val_s;

    function automatic logic [CH_W-1:0] ch_of(input logic [IDX_W-1:0] i);
        return CH_MAP[int'(i)*CH_W +: CH_W];
    endfunction

`ifdef POT_IIR_EN
    function automatic logic [RES_W-1:0] smooth(input logic [RES_W-1:0] old_v,
                                                input logic [RES_W-1:0] new_v);
        logic signed [RES_W:0] diff;
        diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
        // Result always lies between old and new, so modulo-2^RES_W addition is exact
        return old_v + RES_W'(diff >>> 2);
    endfunction
`endif

    // Slot that follows the current one, and whether the current slot closes a scan
    always_comb begin
        if (idx_r == IDX_LAST) begin
            next_idx_s = '0;
            wrap_s     = 1'b1;
        end else begin
            next_idx_s = idx_r + 1'b1;
            wrap_s     = 1'b0;
        end
    end

    // Value written into the current slot on a completed conversion
    always_comb begin
`ifdef POT_IIR_EN
        if (pot_vld_r[idx_r]) begin
            cap_val_s = smooth(pot_vals_r[int'(idx_r)*RES_W +: RES_W], res);
        end else begin
            cap_val_s = res;
        end
`else
        cap_val_s = res;
`endif
    end

    // Scan sequencer: request, wait/timeout, capture, settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= '0;
            tmo_cnt_r     <= '0;
            settle_cnt_r  <= '0;
            strt_cnv_r    <= 1'b0;
            chnnl_r       <= CH_MAP[CH_W-1:0];
            pot_vals_r    <= '0;
            pot_vld_r     <= '0;
            scan_done_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            strt_cnv_r  <= 1'b0;
            scan_done_r <= 1'b0;
            if (clr_err) begin
                timeout_err_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r    <= ST_START;
                        strt_cnv_r <= 1'b1;
                        chnnl_r    <= ch_of(idx_r);
                    end
                end
                ST_START: begin
                    state_r   <= ST_WAIT;
                    tmo_cnt_r <= '0;
                end
                ST_WAIT: begin
                    if (cnv_cmplt || (tmo_cnt_r == TMO_LAST)) begin
                        // A completion on the last allowed cycle wins over the timeout
                        if (cnv_cmplt) begin
                            pot_vals_r[int'(idx_r)*RES_W +: RES_W] <= cap_val_s;
                            pot_vld_r[idx_r] <= 1'b1;
                        end else begin
                            timeout_err_r <= 1'b1;
                        end
                        tmo_cnt_r   <= '0;
                        idx_r       <= next_idx_s;
                        scan_done_r <= wrap_s;
                        if (SETTLE_CYC == 0) begin
                            if (en) begin
                                state_r    <= ST_START;
                                strt_cnv_r <= 1'b1;
                                chnnl_r    <= ch_of(next_idx_s);
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            state_r      <= ST_SETTLE;
                            settle_cnt_r <= '0;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SET_LAST) begin
                        settle_cnt_r <= '0;
                        if (en) begin
                            state_r    <= ST_START;
                            strt_cnv_r <= 1'b1;
                            chnnl_r    <= ch_of(idx_r);
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign strt_cnv    = strt_cnv_r;
    assign chnnl       = chnnl_r;
    assign pot_vals    = pot_vals_r;
    assign pot_vld     = pot_vld_r;
    assign scan_done   = scan_done_r;
    assign timeout_err = timeout_err_r;

endmodule
